// File: rtl/llsc_resv_table_pkg.sv
`default_nettype none
// ============================================================================
// Module      : llsc_resv_table_pkg
// Description : Shared memory-instruction types and LL/SC table sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package llsc_resv_table_pkg;

    typedef enum logic [2:0] {
        IS_NOP_INST   = 3'd0,
        IS_LD_INST    = 3'd1,
        IS_LDL_INST   = 3'd2,
        IS_STQ_INST   = 3'd3,
        IS_STQ_C_INST = 3'd4,
        IS_AMO_INST   = 3'd5
    } MEM_INST_TYPE;

    localparam int LLSC_SIZE = 8;

endpackage
`default_nettype wire

// File: rtl/llsc_resv_table_if.sv
`default_nettype none
// ============================================================================
// Module      : llsc_resv_table_if
// Description : Request, snoop and response bundle of the LL/SC table.
// Revision    : 1.0 - initial release
// ============================================================================
interface llsc_resv_table_if
    import llsc_resv_table_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 64,
    parameter int DEPTH     = LLSC_SIZE
);

    MEM_INST_TYPE              req_type [NUM_PORTS];
    logic [ADDR_W-1:0]         req_addr [NUM_PORTS];
    logic                      snoop_valid;
    logic [ADDR_W-1:0]         snoop_addr;
    logic                      flush;
    logic [NUM_PORTS-1:0]      resp_valid;
    logic [NUM_PORTS-1:0]      sc_success;
    logic                      full;
    logic [$clog2(DEPTH):0]    occupancy;

    modport master (
        output req_type, req_addr, snoop_valid, snoop_addr, flush,
        input  resp_valid, sc_success, full, occupancy
    );

    modport slave (
        input  req_type, req_addr, snoop_valid, snoop_addr, flush,
        output resp_valid, sc_success, full, occupancy
    );

endinterface
`default_nettype wire

// File: rtl/llsc_resv_table_timer.sv
`default_nettype none
// ============================================================================
// Module      : llsc_entry_timer
// Description : Per-entry loadable down-counter with an expire pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module llsc_entry_timer #(
    parameter int TIMEOUT = 1024
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic i_clear,
    input  wire logic i_load,
    input  wire logic i_dec,
    output logic      o_expire
);

    localparam int                 c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_LOAD  = c_CNT_W'(TIMEOUT);

    logic [c_CNT_W-1:0] r_count;

    // Expiry is the decrement that would take the counter from 1 to 0.
    assign o_expire = i_dec && (r_count == c_CNT_W'(1));

    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_LOAD;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/llsc_resv_table.sv
`default_nettype none
// ============================================================================
// Module      : llsc_resv_table
// Description : Multi-port LL/SC reservation table with snoop, flush,
//               timeout and round-robin eviction; results one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module llsc_resv_table
    import llsc_resv_table_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int DEPTH      = LLSC_SIZE,
    parameter int ADDR_W     = 64,
    parameter int LINE_OFF_W = 3,
    parameter int TIMEOUT    = 1024
) (
    input  wire logic        clock,
    input  wire logic        reset,
    llsc_resv_table_if.slave bus
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_OCC_W = $clog2(DEPTH) + 1;
    localparam int c_TAG_W = ADDR_W - LINE_OFF_W;

    typedef logic [c_TAG_W-1:0] tag_t;

    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_good;
    tag_t                 r_tag [DEPTH];
    logic [c_IDX_W-1:0]   r_victim;
    logic [NUM_PORTS-1:0] r_resp;
    logic [NUM_PORTS-1:0] r_succ;
    logic                 r_full;
    logic [c_OCC_W-1:0]   r_occ;

    logic [DEPTH-1:0]     w_valid;
    logic [DEPTH-1:0]     w_good;
    tag_t                 w_tag [DEPTH];
    logic [DEPTH-1:0]     w_refresh;
    logic [DEPTH-1:0]     w_dec;
    logic [DEPTH-1:0]     w_expire;
    logic [DEPTH-1:0]     w_valid_n;
    logic [c_IDX_W-1:0]   w_victim;
    logic [NUM_PORTS-1:0] w_resp;
    logic [NUM_PORTS-1:0] w_succ;
    tag_t                 w_req_tag;
    logic                 w_hit;
    logic                 w_free;
    logic [c_IDX_W-1:0]   w_hit_idx;
    logic [c_IDX_W-1:0]   w_free_idx;
    logic [c_IDX_W-1:0]   w_slot;
    logic [c_OCC_W-1:0]   w_occ;
    logic                 w_unused_lsb;

    // Working copy of the table; each port sees the edits of lower ports.
    always_comb begin
        w_valid    = r_valid;
        w_good     = r_good;
        w_tag      = r_tag;
        w_refresh  = '0;
        w_victim   = r_victim;
        w_resp     = '0;
        w_succ     = '0;
        w_req_tag  = '0;
        w_hit      = 1'b0;
        w_free     = 1'b0;
        w_hit_idx  = '0;
        w_free_idx = '0;
        w_slot     = '0;
        if (bus.flush) begin
            w_valid = '0;
            w_good  = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.req_type[p] == IS_STQ_C_INST) w_resp[p] = 1'b1;
            end
        end else begin
            if (bus.snoop_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_valid[i] && (w_tag[i] == bus.snoop_addr[ADDR_W-1:LINE_OFF_W]))
                        w_good[i] = 1'b0;
                end
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                w_req_tag  = bus.req_addr[p][ADDR_W-1:LINE_OFF_W];
                w_hit      = 1'b0;
                w_hit_idx  = '0;
                w_free     = 1'b0;
                w_free_idx = '0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_valid[i] && (w_tag[i] == w_req_tag)) begin
                        w_hit     = 1'b1;
                        w_hit_idx = c_IDX_W'(i);
                    end
                end
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (!w_valid[i]) begin
                        w_free     = 1'b1;
                        w_free_idx = c_IDX_W'(i);
                    end
                end
                case (bus.req_type[p])
                    IS_LDL_INST: begin
                        if (w_hit) begin
                            w_slot = w_hit_idx;
                        end else if (w_free) begin
                            w_slot = w_free_idx;
                        end else begin
                            w_slot   = w_victim;
                            w_victim = w_victim + c_IDX_W'(1);
                        end
                        w_valid[w_slot]   = 1'b1;
                        w_good[w_slot]    = 1'b1;
                        w_tag[w_slot]     = w_req_tag;
                        w_refresh[w_slot] = 1'b1;
                    end
                    IS_STQ_C_INST: begin
                        w_resp[p] = 1'b1;
                        if (w_hit) begin
                            w_succ[p]          = w_good[w_hit_idx];
                            w_valid[w_hit_idx] = 1'b0;
                            w_good[w_hit_idx]  = 1'b0;
                        end
                    end
                    IS_STQ_INST: begin
                        if (w_hit) w_good[w_hit_idx] = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Timeout is applied after all port activity of the cycle.
    assign w_dec     = (TIMEOUT != 0) ? (w_valid & ~w_refresh) : '0;
    assign w_valid_n = w_valid & ~w_expire;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_timer
            llsc_entry_timer #(
                .TIMEOUT (TIMEOUT)
            ) u_timer (
                .clock    (clock),
                .reset    (reset),
                .i_clear  (bus.flush),
                .i_load   (w_refresh[gi]),
                .i_dec    (w_dec[gi]),
                .o_expire (w_expire[gi])
            );
        end
    endgenerate

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) w_occ = w_occ + c_OCC_W'(w_valid_n[i]);
    end

    always_comb begin
        w_unused_lsb = ^bus.snoop_addr[LINE_OFF_W-1:0];
        for (int p = 0; p < NUM_PORTS; p++)
            w_unused_lsb = w_unused_lsb ^ (^bus.req_addr[p][LINE_OFF_W-1:0]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid  <= '0;
            r_good   <= '0;
            for (int i = 0; i < DEPTH; i++) r_tag[i] <= '0;
            r_victim <= '0;
            r_resp   <= '0;
            r_succ   <= '0;
            r_full   <= 1'b0;
            r_occ    <= '0;
        end else begin
            r_valid  <= w_valid_n;
            r_good   <= w_good;
            r_tag    <= w_tag;
            r_victim <= w_victim;
            r_resp   <= w_resp;
            r_succ   <= w_succ;
            r_full   <= &w_valid_n;
            r_occ    <= w_occ;
        end
    end

    assign bus.resp_valid = r_resp;
    assign bus.sc_success = r_succ;
    assign bus.full       = r_full;
    assign bus.occupancy  = r_occ;

endmodule
`default_nettype wire

// File: doc/llsc_resv_table.md
Name: llsc_resv_table

Overview:
- Parametrised next-generation load-locked/store-conditional reservation table for the superscalar core.
- Supports NUM_PORTS memory-issue ports per cycle, DEPTH reservations, line-granular address matching, external snoop invalidation, global flush, per-entry timeout and round-robin eviction when full.
- Sits beside the LSQ/commit stage; its SC results are registered and feed the ROB one cycle after request.

Parameters:
- NUM_PORTS, 2, memory-issue ports per cycle; port 0 is oldest in program order.
- DEPTH, 8, reservation entries; a power of 2, at least 2.
- ADDR_W, 64, address width.
- LINE_OFF_W, 3, low address bits ignored in tag compare.
- TIMEOUT, 1024, cycles a reservation lives without refresh; 0 disables timeout.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_type  in  NUM_PORTS x MEM_INST_TYPE  per-port type; IS_LDL_INST, IS_STQ_C_INST and IS_STQ_INST act, all other types are no-ops.
- req_addr  in  NUM_PORTS x ADDR_W  per-port address.
- snoop_valid  in  1  a remote write was observed.
- snoop_addr  in  ADDR_W  address of the remote write.
- flush  in  1  drop all reservations (exception or context switch).
- resp_valid  out  NUM_PORTS  registered; high one cycle after a port issued IS_STQ_C_INST.
- sc_success  out  NUM_PORTS  registered SC result; qualified by resp_valid.
- full  out  1  registered; all DEPTH entries valid.
- occupancy  out  $clog2(DEPTH)+1  registered count of valid entries.

Behaviour:
- State per entry: valid, good, tag = addr[ADDR_W-1:LINE_OFF_W], timer. Also one victim pointer, $clog2(DEPTH) bits.
- Invariant: at most one valid entry per tag.
- Reset: all entries invalid, good 0, timers 0, victim 0. All outputs 0.
- Latency: requests are evaluated in cycle N. The table update, resp_valid, sc_success, full and occupancy appear in cycle N+1. Zero-bubble: a new request may issue every cycle on every port.
- Per-cycle evaluation order, applied to a working copy of the registered state:
  1. If flush is high: every entry is cleared. All SC requests in that cycle respond with resp_valid=1 and sc_success=0. All other requests are ignored. Victim pointer is unchanged.
  2. Otherwise, snoop: a valid entry whose tag matches snoop_addr gets good=0. Valid is kept.
  3. Ports are processed in order 0..NUM_PORTS-1. Each port sees the effects of all lower-numbered ports in the same cycle.
  4. Timeout is applied last. For any valid entry not refreshed this cycle: timer==1 makes valid=0; timer>1 decrements the timer. Requests in this cycle still see an entry with timer==1 as valid.
- IS_LDL_INST on a tag hit: good=1 and timer=TIMEOUT (re-arm).
- IS_LDL_INST on a miss with a free entry: allocate the lowest-index invalid entry with valid=1, good=1, timer=TIMEOUT.
- IS_LDL_INST on a miss with the table full: overwrite the entry at the victim pointer; the victim pointer then increments modulo DEPTH. The victim pointer advances only on eviction.
- IS_STQ_C_INST on a hit with good=1: sc_success=1 and the entry is invalidated.
- IS_STQ_C_INST on a hit with good=0: sc_success=0 and the entry is invalidated.
- IS_STQ_C_INST on a miss: sc_success=0.
- IS_STQ_INST on a hit: good=0 and valid is kept. On a miss: no effect. No response is produced.
- TIMEOUT=0: timers are not used and entries never expire.
- full and occupancy reflect the post-update state.

Decomposition:
- Shared package holds the MEM_INST_TYPE enum (IS_LDL_INST, IS_STQ_C_INST, IS_STQ_INST) and the default DEPTH constant LLSC_SIZE. The package is not redefined locally.
- Natural sub-module: llsc_entry_timer, a per-entry loadable down-counter with an expire pulse, instantiated DEPTH times.
- The sequential port-evaluation loop stays in the top module.

Test Plan:
- Reset, then port0 LDL 0x100 in cycle 1 and port0 STQ_C 0x104 in cycle 3 (same line) -> cycle 4: resp_valid[0]=1, sc_success[0]=1, occupancy=0.
- Same cycle: port0 LDL 0x200 and port1 STQ_C 0x200 -> next cycle: resp_valid[1]=1, sc_success[1]=1. Then port0 STQ_C 0x200 alone -> sc_success[0]=0 (no matching entry).
- LDL 0x300, then snoop_valid=1 with snoop_addr=0x300, then STQ_C 0x300 -> sc_success=0. Before the STQ_C, occupancy=1.
- Fill with DEPTH=8 distinct LDLs -> full=1, occupancy=8. A 9th LDL 0x900 evicts entry 0 and the victim pointer becomes 1. STQ_C to entry 0's old address -> sc_success=0. STQ_C 0x900 -> sc_success=1.
- TIMEOUT=4: LDL 0x400, wait 4 cycles, then STQ_C 0x400 -> sc_success=0. Repeat with an LDL refresh at cycle 3 -> sc_success=1.
- Same cycle: flush with port1 STQ_C on a good entry -> resp_valid[1]=1, sc_success[1]=0; next cycle full=0, occupancy=0. Assert reset mid-run -> all outputs 0 on the next cycle.
